datapath_sequencer: RTL and testbench

- Control-side counterpart to the regfile/ALU/RAM datapath: accepts one packed instruction per valid/ready handshake and drives the datapath control word over one or more cycles.
- Datapath control word: write, writeReg, readA, readB, sel, muxSel, cin, writeRam, plus a write-back data select.
- Sequences multi-cycle RAM loads, latches ALU status flags, and signals retirement.
- Sits between an instruction source (bench, FIFO or future fetch unit) and the datapath top.

---
 rtl/datapath_sequencer_pkg.sv | 40 ++++
 rtl/datapath_sequencer_if.sv | 31 +++
 rtl/datapath_sequencer.sv | 132 +++++++++++++
 tb/tb_datapath_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_sequencer_pkg.sv
// rtl/datapath_sequencer_pkg.sv - opcodes, state encoding and instruction field helpers
package datapath_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_ALU   = 3'd1,
        OP_CMP   = 3'd2,
        OP_LOAD  = 3'd3,
        OP_STORE = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_e;

    localparam int OP_LSB = 21;
    localparam int RD_LSB = 16;
    localparam int RA_LSB = 11;
    localparam int RB_LSB = 6;
    localparam int FN_LSB = 1;
    localparam int CI_BIT = 0;

    localparam logic [4:0] SEL_PASSB_DEF = 5'b00110;

    function automatic op_e instr_op(input logic [23:0] i);
        return op_e'(i[OP_LSB +: 3]);
    endfunction

    function automatic logic [4:0] instr_reg(input logic [23:0] i, input int lsb);
        return i[lsb +: 5];
    endfunction

    function automatic logic instr_ci(input logic [23:0] i);
        return i[CI_BIT];
    endfunction

endpackage

// File: rtl/datapath_sequencer_if.sv
// rtl/datapath_sequencer_if.sv - instruction handshake and datapath control word bundle
interface datapath_sequencer_if;
    logic [23:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  status;
    logic        write;
    logic [4:0]  writeReg;
    logic [4:0]  readA;
    logic [4:0]  readB;
    logic [4:0]  sel;
    logic        muxSel;
    logic        cin;
    logic        writeRam;
    logic        dataSel;
    logic [3:0]  flags;
    logic        done;
    logic        err;

    modport master (
        output instr, instr_valid, status,
        input  instr_ready, write, writeReg, readA, readB, sel, muxSel,
               cin, writeRam, dataSel, flags, done, err
    );

    modport slave (
        input  instr, instr_valid, status,
        output instr_ready, write, writeReg, readA, readB, sel, muxSel,
               cin, writeRam, dataSel, flags, done, err
    );
endinterface

// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - multi-cycle control sequencer for the regfile/ALU/RAM datapath
module datapath_sequencer
    import datapath_sequencer_pkg::*;
#(
    parameter logic [4:0] SEL_PASSB  = SEL_PASSB_DEF,
    parameter int         RAM_RD_LAT = 1
) (
    input logic           clock,
    input logic           reset,
    datapath_sequencer_if.slave bus
);

    // WAIT spans RAM_RD_LAT-1 cycles; the counter ends on zero.
    localparam logic [1:0] WAIT_INIT = (RAM_RD_LAT > 1) ? 2'(RAM_RD_LAT - 2) : 2'd0;

    state_e      state;
    logic [23:0] instr_q;
    logic [1:0]  wait_cnt;
    logic [3:0]  flags_q;
    op_e         op;
    logic [4:0]  rd, ra, rb, fn;
    logic        ci;

    assign op = instr_op(instr_q);
    assign rd = instr_reg(instr_q, RD_LSB);
    assign ra = instr_reg(instr_q, RA_LSB);
    assign rb = instr_reg(instr_q, RB_LSB);
    assign fn = instr_reg(instr_q, FN_LSB);
    assign ci = instr_ci(instr_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            instr_q  <= '0;
            wait_cnt <= '0;
            flags_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state <= S_IDLE;
                    case (op)
                        OP_ALU, OP_CMP: flags_q <= bus.status;
                        OP_LOAD: begin
                            if (RAM_RD_LAT == 1) begin
                                state <= S_WB;
                            end else begin
                                state    <= S_WAIT;
                                wait_cnt <= WAIT_INIT;
                            end
                        end
                        default: ;
                    endcase
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= S_WB;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_WB:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.flags  = flags_q;
    assign bus.muxSel = 1'b0;

    // Control word comes only from registered state and instruction.
    always_comb begin
        bus.instr_ready = (state == S_IDLE);
        bus.write       = 1'b0;
        bus.writeReg    = '0;
        bus.readA       = '0;
        bus.readB       = '0;
        bus.sel         = '0;
        bus.cin         = 1'b0;
        bus.writeRam    = 1'b0;
        bus.dataSel     = 1'b0;
        bus.done        = 1'b0;
        bus.err         = 1'b0;
        case (state)
            S_EXEC: begin
                case (op)
                    OP_NOP: bus.done = 1'b1;
                    OP_ALU, OP_CMP: begin
                        bus.readA    = ra;
                        bus.readB    = rb;
                        bus.sel      = fn;
                        bus.cin      = ci;
                        bus.writeReg = rd;
                        bus.write    = (op == OP_ALU);
                        bus.done     = 1'b1;
                    end
                    OP_LOAD: begin
                        bus.readB = rb;
                        bus.sel   = SEL_PASSB;
                    end
                    OP_STORE: begin
                        bus.readA    = ra;
                        bus.readB    = rb;
                        bus.sel      = SEL_PASSB;
                        bus.writeRam = 1'b1;
                        bus.done     = 1'b1;
                    end
                    default: bus.err = 1'b1;
                endcase
            end
            S_WAIT: begin
                bus.readB = rb;
                bus.sel   = SEL_PASSB;
            end
            S_WB: begin
                bus.readB    = rb;
                bus.sel      = SEL_PASSB;
                bus.writeReg = rd;
                bus.write    = 1'b1;
                bus.dataSel  = 1'b1;
                bus.done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - scoreboard bench for datapath_sequencer at read latencies 1 and 3
module tb_datapath_sequencer;

    typedef struct packed {
        logic       write;
        logic [4:0] wreg;
        logic [4:0] ra;
        logic [4:0] rb;
        logic [4:0] sel;
        logic       mux;
        logic       cin;
        logic       wram;
        logic       dsel;
        logic       done;
        logic       err;
    } cw_t;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        use3;
    logic [23:0] in_instr;
    logic [3:0]  in_status;
    int          errors;
    int          checks;
    cw_t         exp_q[$];
    cw_t         cw;
    cw_t         obs;
    logic        o_ready;
    logic [3:0]  o_flags;

    datapath_sequencer_if bus1();
    datapath_sequencer_if bus3();

    assign bus1.instr       = in_instr;
    assign bus3.instr       = in_instr;
    assign bus1.status      = in_status;
    assign bus3.status      = in_status;
    assign bus1.instr_valid = in_valid & ~use3;
    assign bus3.instr_valid = in_valid & use3;

    datapath_sequencer #(.SEL_PASSB(5'b00110), .RAM_RD_LAT(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave)
    );
    datapath_sequencer #(.SEL_PASSB(5'b00110), .RAM_RD_LAT(3)) dut3 (
        .clock(clock), .reset(reset), .bus(bus3.slave)
    );

    always_comb begin
        if (use3) begin
            obs = {bus3.write, bus3.writeReg, bus3.readA, bus3.readB, bus3.sel, bus3.muxSel,
                   bus3.cin, bus3.writeRam, bus3.dataSel, bus3.done, bus3.err};
            o_ready = bus3.instr_ready;
            o_flags = bus3.flags;
        end else begin
            obs = {bus1.write, bus1.writeReg, bus1.readA, bus1.readB, bus1.sel, bus1.muxSel,
                   bus1.cin, bus1.writeRam, bus1.dataSel, bus1.done, bus1.err};
            o_ready = bus1.instr_ready;
            o_flags = bus1.flags;
        end
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [23:0] mk(input logic [2:0] op, input logic [4:0] rd,
                                       input logic [4:0] ra, input logic [4:0] rb,
                                       input logic [4:0] fn, input logic ci);
        return {op, rd, ra, rb, fn, ci};
    endfunction

    // Expected control word for every cycle from EXEC to retirement.
    function automatic void push_expect(input logic [23:0] i, input int lat);
        cw_t w;
        logic [2:0] op;
        op = i[23:21];
        w  = '0;
        case (op)
            3'd0: begin
                w.done = 1'b1;
                exp_q.push_back(w);
            end
            3'd1, 3'd2: begin
                w.write = (op == 3'd1);
                w.wreg  = i[20:16];
                w.ra    = i[15:11];
                w.rb    = i[10:6];
                w.sel   = i[5:1];
                w.cin   = i[0];
                w.done  = 1'b1;
                exp_q.push_back(w);
            end
            3'd3: begin
                w.rb  = i[10:6];
                w.sel = 5'b00110;
                for (int k = 0; k < lat; k++) exp_q.push_back(w);
                w.write = 1'b1;
                w.wreg  = i[20:16];
                w.dsel  = 1'b1;
                w.done  = 1'b1;
                exp_q.push_back(w);
            end
            3'd4: begin
                w.ra   = i[15:11];
                w.rb   = i[10:6];
                w.sel  = 5'b00110;
                w.wram = 1'b1;
                w.done = 1'b1;
                exp_q.push_back(w);
            end
            default: begin
                w.err = 1'b1;
                exp_q.push_back(w);
            end
        endcase
    endfunction

    // Called at an IDLE negedge; the accept happens on the following posedge.
    task automatic issue(input logic [23:0] i, input logic on3);
        use3     = on3;
        in_instr = i;
        in_valid = 1'b1;
        push_expect(i, on3 ? 3 : 1);
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        use3 = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (obs !== cw_t'(0)) begin
            errors++;
            $display("FAIL reset_word: got %h expected %h", obs, cw_t'(0));
        end
        checks++;
        if ({bus1.instr_ready, bus3.instr_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 11", {bus1.instr_ready, bus3.instr_ready});
        end
        checks++;
        if ({bus1.flags, bus3.flags} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %h expected 00", {bus1.flags, bus3.flags});
        end
        reset = 1'b0;
    endtask

    task automatic test_alu();
        @(negedge clock);
        in_status = 4'b1010;
        issue(mk(3'd1, 5'd3, 5'd1, 5'd2, 5'b00010, 1'b1), 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge clock);
            cw = exp_q.pop_front();
            checks++;
            if (obs !== cw) begin
                errors++;
                $display("FAIL alu_word: got %h expected %h", obs, cw);
            end
        end
        @(negedge clock);
        checks++;
        if (o_flags !== 4'b1010) begin
            errors++;
            $display("FAIL alu_flags: got %b expected 1010", o_flags);
        end
        in_status = 4'b0110;
        issue(mk(3'd2, 5'd9, 5'd4, 5'd8, 5'b01100, 1'b0), 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge clock);
            cw = exp_q.pop_front();
            checks++;
            if (obs !== cw) begin
                errors++;
                $display("FAIL cmp_word: got %h expected %h", obs, cw);
            end
        end
        @(negedge clock);
        checks++;
        if (o_flags !== 4'b0110) begin
            errors++;
            $display("FAIL cmp_flags: got %b expected 0110", o_flags);
        end
    endtask

    task automatic test_load();
        in_status = 4'b0001;
        for (int lat = 0; lat < 2; lat++) begin
            @(negedge clock);
            issue(mk(3'd3, 5'd7, 5'd0, 5'd4, 5'd0, 1'b0), lat[0]);
            while (exp_q.size() != 0) begin
                @(negedge clock);
                cw = exp_q.pop_front();
                checks++;
                if (obs !== cw) begin
                    errors++;
                    $display("FAIL load_word lat%0d: got %h expected %h", lat ? 3 : 1, obs, cw);
                end
            end
            @(negedge clock);
            checks++;
            if (o_flags !== (lat ? 4'b0000 : 4'b0110) || obs.write !== 1'b0) begin
                errors++;
                $display("FAIL load_after lat%0d: got flags=%b write=%b expected flags=%b write=0",
                         lat ? 3 : 1, o_flags, obs.write, lat ? 4'b0000 : 4'b0110);
            end
        end
    endtask

    task automatic test_store();
        @(negedge clock);
        in_status = 4'b0101;
        issue(mk(3'd4, 5'd0, 5'd5, 5'd6, 5'd0, 1'b0), 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge clock);
            cw = exp_q.pop_front();
            checks++;
            if (obs !== cw) begin
                errors++;
                $display("FAIL store_word: got %h expected %h", obs, cw);
            end
        end
        @(negedge clock);
        checks++;
        if (o_flags !== 4'b0110 || obs.wram !== 1'b0) begin
            errors++;
            $display("FAIL store_after: got flags=%b writeRam=%b expected flags=0110 writeRam=0",
                     o_flags, obs.wram);
        end
    endtask

    task automatic test_illegal();
        @(negedge clock);
        issue(mk(3'd6, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1), 1'b0);
        issue_nop_check: while (exp_q.size() != 0) begin
            @(negedge clock);
            cw = exp_q.pop_front();
            checks++;
            if (obs !== cw) begin
                errors++;
                $display("FAIL illegal_word: got %h expected %h", obs, cw);
            end
        end
        @(negedge clock);
        checks++;
        if (o_ready !== 1'b1 || obs.err !== 1'b0) begin
            errors++;
            $display("FAIL illegal_after: got ready=%b err=%b expected ready=1 err=0", o_ready, obs.err);
        end
        issue(mk(3'd0, 5'd1, 5'd2, 5'd3, 5'd4, 1'b1), 1'b0);
        while (exp_q.size() != 0) begin
            @(negedge clock);
            cw = exp_q.pop_front();
            checks++;
            if (obs !== cw) begin
                errors++;
                $display("FAIL nop_word: got %h expected %h", obs, cw);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] prog [3];
        int dones;
        prog[0] = mk(3'd1, 5'd1, 5'd10, 5'd11, 5'd1, 1'b0);
        prog[1] = mk(3'd1, 5'd2, 5'd12, 5'd13, 5'd3, 1'b1);
        prog[2] = mk(3'd1, 5'd0, 5'd14, 5'd15, 5'd7, 1'b0);
        dones = 0;
        use3 = 1'b0;
        in_status = 4'b0011;
        @(negedge clock);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clock);
            checks++;
            if (o_ready !== (k % 2 == 0)) begin
                errors++;
                $display("FAIL b2b_ready cycle%0d: got %b expected %b", k, o_ready, (k % 2 == 0));
            end
            if (obs.done === 1'b1) begin
                dones++;
                cw = (exp_q.size() != 0) ? exp_q.pop_front() : cw_t'(0);
                checks++;
                if (obs !== cw) begin
                    errors++;
                    $display("FAIL b2b_word cycle%0d: got %h expected %h", k, obs, cw);
                end
            end
            if (k % 2 == 0) begin
                in_instr = prog[k / 2];
                in_valid = 1'b1;
                push_expect(prog[k / 2], 1);
            end
            if (k == 5) in_valid = 1'b0;
        end
        checks++;
        if (dones != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d pending=%0d expected 3 pending=0", dones, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_load();
        @(negedge clock);
        in_status = 4'b1111;
        issue(mk(3'd1, 5'd4, 5'd5, 5'd6, 5'd2, 1'b0), 1'b1);
        while (exp_q.size() != 0) begin
            @(negedge clock);
            cw = exp_q.pop_front();
            checks++;
            if (obs !== cw) begin
                errors++;
                $display("FAIL rml_alu_word: got %h expected %h", obs, cw);
            end
        end
        @(negedge clock);
        checks++;
        if (o_flags !== 4'b1111) begin
            errors++;
            $display("FAIL rml_flags_set: got %b expected 1111", o_flags);
        end
        issue(mk(3'd3, 5'd7, 5'd0, 5'd4, 5'd0, 1'b0), 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            cw = exp_q.pop_front();
            checks++;
            if (obs !== cw) begin
                errors++;
                $display("FAIL rml_load_word cycle%0d: got %h expected %h", k, obs, cw);
            end
        end
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (obs.write !== 1'b0 || o_flags !== 4'b0000) begin
            errors++;
            $display("FAIL rml_in_reset: got write=%b flags=%b expected write=0 flags=0000",
                     obs.write, o_flags);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (obs.write !== 1'b0 || o_ready !== 1'b1) begin
                errors++;
                $display("FAIL rml_after cycle%0d: got write=%b ready=%b expected write=0 ready=1",
                         k, obs.write, o_ready);
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        use3      = 1'b0;
        in_instr  = '0;
        in_status = '0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_illegal();
        test_back_to_back();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
